// File: rtl/fetch_seq_pkg.sv
// Shared definitions for the fetch sequencer: state encoding, PC step and
// the instruction-alignment helper.
package fetch_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4,
    S_FAULT  = 3'd5
  } state_e;

  localparam int         PC_STEP    = 4;
  localparam logic [1:0] ALIGN_MASK = 2'(PC_STEP - 1);

  function automatic logic is_aligned(input logic [1:0] lo);
    return (lo & ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Clearable saturating counter; tc_o says the next increment reaches LIMIT,
// so the caller can leave on the same edge that would hit the limit.
module fetch_timeout_ctr #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                             cnt_d = '0;
    else if (inc_i && cnt_q != W'(LIMIT))  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q >= W'(LIMIT - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/decode/execute sequencing FSM: drives the external PC register's
// hold/advance/load controls and the instruction-memory handshake.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int INSTR_W      = 32,
  parameter int RESET_VECTOR = 0,
  parameter int ACK_TIMEOUT  = 15,
  parameter int CNT_W        = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  pc_value,
  output logic               pc_enable,
  output logic [ADDR_W-1:0]  pc_load_value,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               stall,
  input  logic               jump,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  target,
  input  logic               halt,
  output logic [CNT_W-1:0]   retired,
  output logic               halted,
  output logic               fault,
  output logic [2:0]         state_o
);

  localparam logic [ADDR_W-1:0] RV = ADDR_W'(RESET_VECTOR);

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               to_tc;

  wire in_fetch = (state_q == S_FETCH);

  fetch_timeout_ctr #(.LIMIT(ACK_TIMEOUT)) u_tmo (
    .clk   (clk),
    .reset (reset),
    .clr_i (~in_fetch | imem_ack),
    .inc_i (in_fetch & ~imem_ack),
    .tc_o  (to_tc)
  );

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    retired_d     = retired_q;
    pc_enable     = 1'b1;
    pc_load_value = pc_value;
    imem_req      = 1'b0;
    instr_valid   = 1'b0;
    case (state_q)
      S_IDLE: begin
        pc_load_value = RV;
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        // ack beats the timeout on the same edge
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = S_DECODE;
        end else if (to_tc) begin
          state_d = S_FAULT;
        end
      end
      S_DECODE: begin
        instr_valid = 1'b1;
        state_d     = S_EXEC;
      end
      S_EXEC: begin
        if (halt) begin
          state_d = S_HALT;
        end else if (stall) begin
          state_d = S_EXEC;
        end else if (jump | br_taken) begin
          if (!is_aligned(target[1:0])) begin
            state_d = S_FAULT;
          end else begin
            pc_load_value = target;
            retired_d     = (&retired_q) ? retired_q : retired_q + 1'b1;
            state_d       = S_FETCH;
          end
        end else begin
          pc_enable = 1'b0;
          retired_d = (&retired_q) ? retired_q : retired_q + 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_HALT, S_FAULT: state_d = state_q;
      default:         state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      instr_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  assign imem_addr = pc_value;
  assign instr     = instr_q;
  assign retired   = retired_q;
  assign halted    = (state_q == S_HALT);
  assign fault     = (state_q == S_FAULT);
  assign state_o   = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench: models the PC register and a simple instruction memory,
// and scoreboards every decoded instruction against hand-computed words.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, stall, jump, br_taken, halt;
  logic [7:0]  pc_q, target;
  logic        pc_enable, imem_req, imem_ack, instr_valid, halted, fault;
  logic [7:0]  pc_load_value, imem_addr;
  logic [31:0] imem_rdata, instr;
  logic [15:0] retired;
  logic [2:0]  state_o;
  logic        ack_mode, ack_force;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  // External PC register: load when enabled, else step by 4 (wraps).
  always @(posedge clk) pc_q <= pc_enable ? pc_load_value : pc_q + 8'd4;

  assign imem_rdata = {24'h5A5A5A, imem_addr};
  assign imem_ack   = ack_mode ? imem_req : ack_force;

  fetch_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .pc_value(pc_q),
    .pc_enable(pc_enable), .pc_load_value(pc_load_value),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
    .stall(stall), .jump(jump), .br_taken(br_taken), .target(target),
    .halt(halt), .retired(retired), .halted(halted), .fault(fault),
    .state_o(state_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (reset === 1'b0 && instr_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_unexpected: got instr %0h expected none", instr);
      end else begin
        chk("sb_instr", instr, exp_q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; stall = 1'b0; jump = 1'b0; br_taken = 1'b0;
    halt = 1'b0; target = 8'h00; ack_mode = 1'b1; ack_force = 1'b0;

    // Reset state
    do_reset();
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_pc_en", 32'(pc_enable), 32'd1);
    chk("rst_pc_load", 32'(pc_load_value), 32'h00);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_flags", {30'd0, halted, fault}, 32'd0);

    // Three sequential instructions, 3 cycles each
    exp_q.push_back(32'h5A5A5A00);
    exp_q.push_back(32'h5A5A5A04);
    exp_q.push_back(32'h5A5A5A08);
    start = 1'b1; tick(); start = 1'b0;
    chk("seq_first_addr", 32'(imem_addr), 32'h00);
    tick(9);
    chk("seq_state", 32'(state_o), 32'd1);
    chk("seq_addr", 32'(imem_addr), 32'h0C);
    chk("seq_retired", 32'(retired), 32'd3);

    // Jump to 0x40
    exp_q.push_back(32'h5A5A5A0C);
    tick(2);
    chk("jmp_in_exec", 32'(state_o), 32'd3);
    jump = 1'b1; target = 8'h40; #1;
    chk("jmp_pc_en", 32'(pc_enable), 32'd1);
    chk("jmp_load", 32'(pc_load_value), 32'h40);
    tick(); jump = 1'b0;
    chk("jmp_state", 32'(state_o), 32'd1);
    chk("jmp_addr", 32'(imem_addr), 32'h40);
    chk("jmp_retired", 32'(retired), 32'd4);

    // Misaligned branch target
    exp_q.push_back(32'h5A5A5A40);
    tick(2);
    br_taken = 1'b1; target = 8'h42;
    tick(); br_taken = 1'b0;
    chk("br_state", 32'(state_o), 32'd5);
    chk("br_fault", 32'(fault), 32'd1);
    chk("br_req", 32'(imem_req), 32'd0);
    chk("br_pc", 32'(imem_addr), 32'h40);
    chk("br_retired", 32'(retired), 32'd4);
    tick(3);
    chk("br_fault_sticky", {imem_req, fault, imem_addr}, {1'b0, 1'b1, 8'h40});

    // Ack withheld for 15 FETCH cycles
    do_reset();
    ack_mode = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick(14);
    chk("tmo_cycle15_fetch", 32'(state_o), 32'd1);
    tick();
    chk("tmo_fault_state", 32'(state_o), 32'd5);
    chk("tmo_fault", 32'(fault), 32'd1);

    // Ack on the 15th FETCH cycle completes the fetch
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    tick(14);
    exp_q.push_back(32'h5A5A5A00);
    ack_force = 1'b1; tick(); ack_force = 1'b0;
    chk("ack15_state", 32'(state_o), 32'd2);
    chk("ack15_fault", 32'(fault), 32'd0);
    chk("ack15_valid", 32'(instr_valid), 32'd1);
    tick();

    // Stall 5 cycles, then halt with stall
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_hold", {21'd0, state_o, imem_addr}, {21'd0, 3'd3, 8'h00});
    end
    halt = 1'b1; tick(); halt = 1'b0; stall = 1'b0;
    chk("halt_state", 32'(state_o), 32'd4);
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_pc", 32'(imem_addr), 32'h00);
    chk("halt_retired", 32'(retired), 32'd0);
    start = 1'b1; tick(3); start = 1'b0;
    chk("halt_ignores_start", {21'd0, state_o, imem_addr}, {21'd0, 3'd4, 8'h00});

    // Reset mid-FETCH, late ack in IDLE ignored
    do_reset();
    ack_mode = 1'b1;
    exp_q.push_back(32'h5A5A5A00);
    start = 1'b1; tick(); start = 1'b0;
    tick(3);
    chk("rmid_fetch2", {21'd0, state_o, imem_addr}, {21'd0, 3'd1, 8'h04});
    ack_mode = 1'b0;
    reset = 1'b1; tick();
    chk("rmid_req_drop", 32'(imem_req), 32'd0);
    reset = 1'b0; ack_force = 1'b1; tick(); ack_force = 1'b0;
    chk("rmid_state", 32'(state_o), 32'd0);
    chk("rmid_instr", instr, 32'h0);
    chk("rmid_load", 32'(pc_load_value), 32'h00);

    // PC wrap 0xFC -> 0x00
    ack_mode = 1'b1;
    exp_q.push_back(32'h5A5A5A00);
    start = 1'b1; tick(); start = 1'b0;
    tick(2);
    jump = 1'b1; target = 8'hFC; tick(); jump = 1'b0;
    chk("wrap_fc", 32'(imem_addr), 32'hFC);
    exp_q.push_back(32'h5A5A5AFC);
    tick(3);
    chk("wrap_addr", 32'(imem_addr), 32'h00);
    chk("wrap_retired", 32'(retired), 32'd2);
    exp_q.push_back(32'h5A5A5A00);
    tick(2);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
